// File: rtl/p_arb_enc_n.sv
// Registered N-input priority encoder / arbiter. The grant is held until ack.
// Fixed priority (highest index wins) or round-robin with a rotating search start.
module p_arb_enc_n #(
  parameter  int N  = 4,
  parameter  int RR = 0,
  localparam int W  = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] q,
  output logic         v,
  output logic [N-1:0] gnt,
  output logic         busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] ptr, start, win;
  logic [W:0]   sum;
  logic         found, cap;

  // Descending search from start, wrapping N-1 after 0; fixed priority starts at N-1.
  // sum stays below 2N, which always fits in W+1 bits.
  always_comb begin
    start = (RR != 0) ? ptr : W'(N-1);
    win   = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, start} + (W+1)'(N) - (W+1)'(k);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      if (!found && req[sum[W-1:0]]) begin
        found = 1'b1;
        win   = sum[W-1:0];
      end
    end
  end

  assign cap = en && (|req) && (state == IDLE || ack);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cap) state_nxt = GRANT;
      GRANT:   if (ack && !cap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // q keeps its last value when the grant is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      ptr <= W'(N-1);
    end else if (cap) begin
      q   <= win;
      ptr <= (win == '0) ? W'(N-1) : win - W'(1);
    end
  end

  assign v    = (state == GRANT);
  assign busy = v;

  always_comb begin
    gnt = '0;
    if (v) gnt[q] = 1'b1;
  end

endmodule

// File: tb/tb_p_arb_enc_n.sv
// Bench for p_arb_enc_n: three instances (N=4 fixed, N=4 round-robin, N=16 fixed)
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_p_arb_enc_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] req = '0;

  logic [1:0]  q0, q1;
  logic [3:0]  q2;
  logic        v0, v1, v2, b0, b1, b2;
  logic [3:0]  g0, g1;
  logic [15:0] g2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  p_arb_enc_n #(.N(4),  .RR(0)) u0 (.clk(clk), .rst(rst), .en(en), .req(req[3:0]), .ack(ack),
                                    .q(q0), .v(v0), .gnt(g0), .busy(b0));
  p_arb_enc_n #(.N(4),  .RR(1)) u1 (.clk(clk), .rst(rst), .en(en), .req(req[3:0]), .ack(ack),
                                    .q(q1), .v(v1), .gnt(g1), .busy(b1));
  p_arb_enc_n #(.N(16), .RR(0)) u2 (.clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
                                    .q(q2), .v(v2), .gnt(g2), .busy(b2));

  // Behavioural model: one grant slot per instance.
  int nn[3] = '{4, 4, 16};
  int rr[3] = '{0, 1, 0};
  int mq[3], mptr[3];
  bit mv[3];

  function automatic int winner(int r, int n, int rrm, int p);
    if (rrm == 0) begin
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int i = p; i >= 0; i--) if (r[i]) return i;
      for (int i = n - 1; i > p; i--) if (r[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 3; d++) begin
      int r, w;
      r = int'(req) & ((1 << nn[d]) - 1);
      if (rst) begin
        mv[d] <= 1'b0; mq[d] <= 0; mptr[d] <= nn[d] - 1;
      end else if (en && r != 0 && (!mv[d] || ack)) begin
        w = winner(r, nn[d], rr[d], mptr[d]);
        mv[d] <= 1'b1; mq[d] <= w; mptr[d] <= (w == 0) ? nn[d] - 1 : w - 1;
      end else if (mv[d] && ack) begin
        mv[d] <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int dq[3], dv[3], dg[3], db[3];
    dq = '{int'(q0), int'(q1), int'(q2)};
    dv = '{int'(v0), int'(v1), int'(v2)};
    db = '{int'(b0), int'(b1), int'(b2)};
    dg = '{int'(g0), int'(g1), int'(g2)};
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("model_v[%0d]", d), dv[d], int'(mv[d]));
      chk($sformatf("model_q[%0d]", d), dq[d], mq[d]);
      chk($sformatf("model_gnt[%0d]", d), dg[d], mv[d] ? (1 << mq[d]) : 0);
      chk($sformatf("model_busy[%0d]", d), db[d], int'(mv[d]));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [15:0] r, input logic a, input logic e);
    req = r; ack = a; en = e;
  endtask

  task automatic pulse_rst();
    rst = 1'b1; #1; rst = 1'b0;
  endtask

  int exp_hi[16] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};
  int rr_seq[6]  = '{3, 2, 1, 0, 3, 2};
  int rr_alt[4]  = '{3, 1, 3, 1};

  initial begin
    cyc(); cyc();
    chk("reset_v", int'(v0), 0);
    chk("reset_q", int'(q0), 0);
    chk("reset_gnt", int'(g0), 0);
    rst = 1'b0;

    // Reset mid-grant
    drive(16'h0004, 0, 1); cyc();
    chk("t1_q_before", int'(q0), 2);
    chk("t1_v_before", int'(v0), 1);
    rst = 1'b1; #1;
    chk("t1_async_v", int'(v0), 0);
    chk("t1_async_gnt", int'(g0), 0);
    chk("t1_async_q", int'(q0), 0);
    rst = 1'b0;
    drive(16'h0001, 0, 1); cyc();
    chk("t1_q_after", int'(q0), 0);
    chk("t1_v_after", int'(v0), 1);
    drive(16'h0000, 1, 1); cyc();

    // Fixed priority sweep
    for (int r = 0; r < 16; r++) begin
      drive(16'(r), 0, 1); cyc();
      chk($sformatf("t2_v_req%0d", r), int'(v0), (r != 0) ? 1 : 0);
      if (r != 0) chk($sformatf("t2_q_req%0d", r), int'(q0), exp_hi[r]);
      drive(16'h0000, 1, 1); cyc();
    end

    // Hold until ack, then back-to-back
    drive(16'h0004, 0, 1); cyc();
    chk("t3_q_first", int'(q0), 2);
    drive(16'h0008, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_q_held", int'(q0), 2);
    end
    drive(16'h0008, 1, 1); cyc();
    chk("t3_q_next", int'(q0), 3);
    chk("t3_v_next", int'(v0), 1);
    drive(16'h0000, 1, 1); cyc();
    chk("t3_v_release", int'(v0), 0);

    // Round-robin
    pulse_rst();
    drive(16'h000f, 1, 1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t4_rr_all", int'(q1), rr_seq[i]);
    end
    pulse_rst();
    drive(16'h000a, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4_rr_1010", int'(q1), rr_alt[i]);
    end
    drive(16'h0000, 1, 1); cyc();

    // Enable
    drive(16'h0006, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_en_off_v", int'(v0), 0);
    end
    drive(16'h0006, 0, 1); cyc();
    chk("t5_en_on_q", int'(q0), 2);
    drive(16'h0006, 1, 0); cyc();
    chk("t5_en_ack_v", int'(v0), 0);

    // Wide instance
    drive(16'h8001, 0, 1); cyc();
    chk("t6_q15", int'(q2), 15);
    drive(16'h0001, 1, 1); cyc();
    chk("t6_q0", int'(q2), 0);
    drive(16'h0000, 1, 1); cyc();
    chk("t6_v_off", int'(v2), 0);
    chk("t6_gnt_off", int'(g2), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 85));
      if ($urandom_range(0, 3) == 0) req = req & 16'(1 << $urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) pulse_rst();
      cyc();
    end

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
